// File: rtl/inject_ctl_pkg.sv
// Shared widths, defaults and flit payload type for the injection controller.
package inject_ctl_pkg;

    localparam int unsigned CONTROL_W        = 22;
    localparam int unsigned DATA_W           = 128;
    localparam int unsigned VALID_BIT        = 21;
    localparam int unsigned WAIT_W           = 5;
    localparam int unsigned CNT_W            = 16;
    localparam int unsigned DEF_DEPTH        = 4;
    localparam int unsigned DEF_STARVE_LIMIT = 16;

    localparam logic [WAIT_W-1:0] WAIT_MAX = 5'd31;

    typedef struct packed {
        logic [CONTROL_W-1:0] c;
        logic [DATA_W-1:0]    d;
    } flit_t;

    function automatic logic is_valid(input logic [CONTROL_W-1:0] c);
        return c[VALID_BIT];
    endfunction

endpackage

// File: rtl/inject_ctl_if.sv
// Core-side and router-local-port signals of the injection controller.
interface inject_ctl_if;
    import inject_ctl_pkg::*;

    logic                 core_in_valid;
    logic                 core_in_ready;
    logic [CONTROL_W-1:0] core_in_c;
    logic [DATA_W-1:0]    core_in_d;

    logic                 rtr_ready;
    logic [CONTROL_W-1:0] rtr_ci;
    logic [DATA_W-1:0]    rtr_di;
    logic [CONTROL_W-1:0] rtr_co;
    logic [DATA_W-1:0]    rtr_do;

    logic                 core_out_valid;
    logic [CONTROL_W-1:0] core_out_c;
    logic [DATA_W-1:0]    core_out_d;

    // Environment side: core and router.
    modport master (
        output core_in_valid, core_in_c, core_in_d, rtr_ready, rtr_co, rtr_do,
        input  core_in_ready, rtr_ci, rtr_di, core_out_valid, core_out_c, core_out_d
    );

    // Controller side.
    modport slave (
        input  core_in_valid, core_in_c, core_in_d, rtr_ready, rtr_co, rtr_do,
        output core_in_ready, rtr_ci, rtr_di, core_out_valid, core_out_c, core_out_d
    );

endinterface

// File: rtl/inj_fifo.sv
// Injection FIFO: flit storage, wrapping pointers and occupancy count.
module inj_fifo
    import inject_ctl_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  flit_t                    i_wflit,
    input  logic                     i_pop,
    output flit_t                    o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    flit_t              r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [OCC_W-1:0]   r_count;

    // Storage is deliberately left out of reset; only pointers define content.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wflit;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + OCC_W'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - OCC_W'(1);
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/inject_ctl.sv
// Network-interface injection controller: queues core flits for the router local
// port, tracks head starvation and registers ejected flits back to the core.
module inject_ctl
    import inject_ctl_pkg::*;
#(
    parameter int unsigned DEPTH        = DEF_DEPTH,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                     clk,
    input  logic                     rst,
    inject_ctl_if.slave              bus,
    output logic                     starve,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         inj_cnt,
    output logic [CNT_W-1:0]         ej_cnt
);

    localparam int unsigned       OCC_W     = $clog2(DEPTH) + 1;
    localparam logic [WAIT_W-1:0] STARVE_TH = WAIT_W'(STARVE_LIMIT);

    logic                 w_ready;
    logic                 w_inject;
    logic                 w_push;
    flit_t                w_wflit;
    flit_t                w_head;
    logic [CONTROL_W-1:0] w_ci;
    logic [DATA_W-1:0]    w_di;
    logic [WAIT_W-1:0]    w_wait_nxt;

    logic [WAIT_W-1:0]    r_wait;
    logic                 r_starve;
    logic [CNT_W-1:0]     r_inj_cnt;
    logic [CNT_W-1:0]     r_ej_cnt;
    logic                 r_out_valid;
    logic [CONTROL_W-1:0] r_out_c;
    logic [DATA_W-1:0]    r_out_d;

    // Handshake decisions use the pre-edge count; a full FIFO never bypasses.
    always_comb begin
        w_ready  = rst && (occupancy < OCC_W'(DEPTH));
        w_inject = rst && (occupancy != '0) && bus.rtr_ready;
        w_push   = w_ready && bus.core_in_valid && is_valid(bus.core_in_c);
        w_wflit  = '{c: bus.core_in_c, d: bus.core_in_d};
    end

    inj_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wflit (w_wflit),
        .i_pop   (w_inject),
        .o_head  (w_head),
        .o_count (occupancy)
    );

    // Injection path; the router sees the valid bit set on every presented flit.
    always_comb begin
        w_ci = '0;
        w_di = '0;
        if (w_inject) begin
            w_ci            = w_head.c;
            w_ci[VALID_BIT] = 1'b1;
            w_di            = w_head.d;
        end
    end

    always_comb begin
        w_wait_nxt = r_wait;
        if (w_inject || (occupancy == '0)) begin
            w_wait_nxt = '0;
        end else if (r_wait != WAIT_MAX) begin
            w_wait_nxt = r_wait + WAIT_W'(1);
        end
    end

    // Starve is registered from the next wait value so it tracks the counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wait      <= '0;
            r_starve    <= 1'b0;
            r_inj_cnt   <= '0;
            r_ej_cnt    <= '0;
            r_out_valid <= 1'b0;
            r_out_c     <= '0;
            r_out_d     <= '0;
        end else begin
            r_wait   <= w_wait_nxt;
            r_starve <= (w_wait_nxt >= STARVE_TH);
            if (w_inject) begin
                r_inj_cnt <= r_inj_cnt + CNT_W'(1);
            end
            if (is_valid(bus.rtr_co)) begin
                r_ej_cnt    <= r_ej_cnt + CNT_W'(1);
                r_out_valid <= 1'b1;
                r_out_c     <= bus.rtr_co;
                r_out_d     <= bus.rtr_do;
            end else begin
                r_out_valid <= 1'b0;
                r_out_c     <= '0;
                r_out_d     <= '0;
            end
        end
    end

    assign bus.core_in_ready  = w_ready;
    assign bus.rtr_ci         = w_ci;
    assign bus.rtr_di         = w_di;
    assign bus.core_out_valid = r_out_valid;
    assign bus.core_out_c     = r_out_c;
    assign bus.core_out_d     = r_out_d;
    assign starve             = r_starve;
    assign inj_cnt            = r_inj_cnt;
    assign ej_cnt             = r_ej_cnt;

endmodule

// File: tb/tb_inject_ctl.sv
// Bench for inject_ctl: directed scenarios then random traffic against a queue model.
module tb_inject_ctl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        starve;
    logic [2:0]  occupancy;
    logic [15:0] inj_cnt;
    logic [15:0] ej_cnt;

    inject_ctl_if bus ();

    inject_ctl #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .starve    (starve),
        .occupancy (occupancy),
        .inj_cnt   (inj_cnt),
        .ej_cnt    (ej_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: queued flits as {control, data}.
    logic [149:0] m_q [$];
    int           m_wait;
    logic         m_starve;
    logic [15:0]  m_inj;
    logic [15:0]  m_ej;
    logic         m_ov;
    logic [21:0]  m_oc;
    logic [127:0] m_od;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: drive inputs, check combinational outputs, clock, check registers.
    task automatic cycle(input logic rst_i, input logic v, input logic [21:0] c,
                         input logic [127:0] d, input logic rr,
                         input logic [21:0] co, input logic [127:0] dout);
        int           s;
        logic         inj;
        logic         push;
        logic [149:0] head;
        logic [21:0]  exp_ci;
        logic [127:0] exp_di;
        rst               = rst_i;
        bus.core_in_valid = v;
        bus.core_in_c     = c;
        bus.core_in_d     = d;
        bus.rtr_ready     = rr;
        bus.rtr_co        = co;
        bus.rtr_do        = dout;
        #1;
        s      = m_q.size();
        inj    = rst_i && (s > 0) && rr;
        push   = rst_i && v && (s < DEPTH) && c[21];
        exp_ci = '0;
        exp_di = '0;
        if (inj) begin
            head   = m_q[0];
            exp_ci = head[149:128] | 22'h200000;
            exp_di = head[127:0];
        end
        chk("core_in_ready", 128'(bus.core_in_ready), 128'(rst_i && (s < DEPTH)));
        chk("rtr_ci", 128'(bus.rtr_ci), 128'(exp_ci));
        chk("rtr_di", bus.rtr_di, exp_di);
        @(posedge clk);
        #1;
        if (!rst_i) begin
            m_q.delete();
            m_wait = 0; m_starve = 1'b0; m_inj = '0; m_ej = '0;
            m_ov = 1'b0; m_oc = '0; m_od = '0;
        end else begin
            if (inj || s == 0) m_wait = 0;
            else if (m_wait < 31) m_wait = m_wait + 1;
            m_starve = (m_wait >= LIMIT);
            if (inj) begin
                void'(m_q.pop_front());
                m_inj = m_inj + 16'd1;
            end
            if (push) m_q.push_back({c, d});
            m_ov = co[21];
            m_oc = co[21] ? co : 22'h0;
            m_od = co[21] ? dout : 128'h0;
            if (co[21]) m_ej = m_ej + 16'd1;
        end
        chk("occupancy", 128'(occupancy), 128'(m_q.size()));
        chk("starve", 128'(starve), 128'(m_starve));
        chk("inj_cnt", 128'(inj_cnt), 128'(m_inj));
        chk("ej_cnt", 128'(ej_cnt), 128'(m_ej));
        chk("core_out_valid", 128'(bus.core_out_valid), 128'(m_ov));
        chk("core_out_c", 128'(bus.core_out_c), 128'(m_oc));
        chk("core_out_d", bus.core_out_d, m_od);
    endtask

    task automatic idle(input logic rr, input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 22'h0, 128'h0, rr, 22'h0, 128'h0);
    endtask

    initial begin
        logic [127:0] pat;
        logic [21:0]  rc;
        logic         rr;
        rst = 1'b0;
        bus.core_in_valid = 1'b0; bus.core_in_c = '0; bus.core_in_d = '0;
        bus.rtr_ready = 1'b0; bus.rtr_co = '0; bus.rtr_do = '0;
        m_wait = 0; m_starve = 1'b0; m_inj = '0; m_ej = '0;
        m_ov = 1'b0; m_oc = '0; m_od = '0;
        #2;

        // Reset state.
        cycle(1'b0, 1'b0, 22'h0, 128'h0, 1'b0, 22'h0, 128'h0);
        cycle(1'b0, 1'b0, 22'h0, 128'h0, 1'b0, 22'h0, 128'h0);

        // Single flit, one-cycle latency.
        cycle(1'b1, 1'b1, 22'h200001, 128'h0123456789abcdef0123456789abcdef, 1'b1, 22'h0, 128'h0);
        idle(1'b1, 2);

        // Fill past full with router stalled, then drain in order.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b1, 22'h200010 | 22'(i), rnd128(), 1'b0, 22'h0, 128'h0);
        idle(1'b1, 5);

        // Control word without its valid bit is dropped.
        cycle(1'b1, 1'b1, 22'h000001, rnd128(), 1'b1, 22'h0, 128'h0);
        idle(1'b1, 1);

        // Starvation and recovery.
        cycle(1'b1, 1'b1, 22'h200123, rnd128(), 1'b0, 22'h0, 128'h0);
        idle(1'b0, 20);
        idle(1'b1, 2);

        // Ejection for a single cycle.
        pat = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        cycle(1'b1, 1'b0, 22'h0, 128'h0, 1'b0, 22'h200802, pat);
        idle(1'b0, 2);

        // Reset mid-operation discards queued flits.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b1, 22'h200040 | 22'(i), rnd128(), 1'b0, 22'h0, 128'h0);
        cycle(1'b0, 1'b0, 22'h0, 128'h0, 1'b1, 22'h0, 128'h0);
        idle(1'b1, 3);

        // Random traffic with periodic router stalls and rare resets.
        for (int i = 0; i < 800; i++) begin
            rc = 22'($urandom);
            rc[21] = ($urandom_range(0, 9) != 0);
            if ((i % 60) >= 30 && (i % 60) < 55) rr = 1'b0;
            else rr = 1'($urandom_range(0, 1));
            cycle(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)), rc, rnd128(), rr,
                  22'($urandom), rnd128());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
